spi_master_param: RTL
=====================

# spi_master_param

Parameterised SPI master: the next generation of the fixed-mode, fixed-width SPI master, sitting between the APB slave register block and off-chip SPI devices. It adds:
- run-time CPOL/CPHA selection per frame;
- parameterised word length and SCLK divider;
- multiple one-hot slave selects;
- a valid/ready transmit handshake;
- a one-cycle receive-valid pulse with full-duplex receive data.

## Interface
- WORD_LENGTH, 8, bits per frame, MSB first; legal range ≥ 2.
- CLK_PER_HALF_BIT, 4, clk cycles per SCLK half period (H); legal range ≥ 2.
- NUM_SLAVES, 1, number of SSbar lines; legal range ≥ 1.
- clk  input  1  system clock; every flop is clocked on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_valid  input  1  frame request.
- tx_ready  output  1  high only in IDLE; a frame is accepted on a clk edge where tx_valid & tx_ready.
- tx_data  input  WORD_LENGTH  frame to transmit; sampled on accept.
- slave_sel  input  max(1,$clog2(NUM_SLAVES))  target slave; sampled on accept.
- cpol, cpha  input  1 each  SPI mode; sampled on accept.
- rx_valid  output  1  one-cycle pulse at frame end.
- rx_data  output  WORD_LENGTH  received frame; held stable until the next rx_valid.
- busy  output  1  equals ~tx_ready.
- SCLK  output  1  SPI clock.
- MOSI  output  1  master out.
- MISO  input  1  master in.
- SSbar  output  NUM_SLAVES  active-low slave selects; at most one bit is low at any time.

## Operation
- **FSM states**
  - IDLE →(accept)→ LEAD.
  - LEAD →(H cycles)→ TRANSFER.
  - TRANSFER →(2·WORD_LENGTH SCLK edges done)→ TRAIL.
  - TRAIL →(H cycles)→ IDLE.
- **Accept**
  - Latch tx_data into the shift register, plus cpol, cpha and slave_sel.
  - The SSbar[slave_sel] register goes low on the same edge.
  - If slave_sel ≥ NUM_SLAVES, all SSbar stay high but the frame still runs in full and rx_valid still fires.
- **SCLK**
  - In IDLE, SCLK is registered from the cpol input every cycle.
  - From accept onward, SCLK uses the latched cpol and toggles every H cycles in TRANSFER.
  - Each transition is one edge. Odd-numbered edges are leading edges; even-numbered edges are trailing edges.
  - In TRAIL, SCLK sits at the latched cpol.
- **cpha = 0**
  - MOSI = tx_data[MSB] from the accept edge.
  - MISO is sampled on leading edges.
  - MOSI shifts to the next bit on trailing edges; the final trailing edge leaves MOSI unchanged.
- **cpha = 1**
  - MOSI shifts to the next bit on leading edges; the first leading edge drives the MSB.
  - MISO is sampled on trailing edges.
- **Sampling and receive**
  - MISO is sampled on the same clk edge that toggles SCLK.
  - Received bits shift in MSB first.
  - rx_data is updated only at the TRAIL→IDLE edge.
- **MOSI outside frames:** 0 in IDLE.
- **Mid-frame input changes:** changes on tx_data, cpol, cpha or slave_sel have no effect on the frame in progress.

## Timing
- **Reset values:** tx_ready=1, busy=0, rx_valid=0, rx_data=0, SCLK=0, MOSI=0, SSbar=all 1s, state IDLE.
- **Reset mid-frame:** every output returns to its reset value asynchronously. No rx_valid is produced for the aborted frame.
- **Frame timeline**, with accept at edge 0:
  - SSbar low during cycles 1 … (2·WORD_LENGTH+1)·H.
  - SCLK edge n occurs at clk edge n·H, for n = 1 … 2·WORD_LENGTH.
  - At edge (2·WORD_LENGTH+1)·H, all of the following happen together: SSbar returns high, rx_valid pulses high for one cycle, rx_data updates, state returns to IDLE, and tx_ready rises.
- **Accept-to-rx_valid latency:** (2·WORD_LENGTH+1)·H cycles. For defaults: 17·4 = 68.
- **Back-to-back frames:**
  - tx_valid held high gives re-accept on the edge after rx_valid.
  - SSbar is high for exactly 1 cycle between frames.
  - SCLK re-samples cpol in that IDLE cycle.
- **SCLK divider counter:** width $clog2(CLK_PER_HALF_BIT); wraps at H−1.
- **Edge counter:** width $clog2(2·WORD_LENGTH+1).

## Configuration
- **SPI_MASTER_LOOPBACK_EN defined:**
  - Adds input port loopback (1 bit).
  - While loopback=1, the sampled bit is the current MOSI and MISO is ignored.
  - SCLK, MOSI and SSbar still toggle normally.
- **SPI_MASTER_LOOPBACK_EN undefined:** no loopback port; MISO is always the sample source.

## Test plan
- **Mode 0 frame:** reset; WORD_LENGTH=8, H=4; accept tx_data=0xA5, cpol=0, cpha=0 with MISO driven from a slave model returning 0x3C.
  - MOSI bits 1,0,1,0,0,1,0,1 are stable at each rising SCLK.
  - rx_valid pulses 68 cycles after accept with rx_data=0x3C.
  - SSbar[0] is low for exactly 68 cycles.
- **All four modes:** cpol/cpha = 00, 01, 10, 11 with tx_data 0x81 to a slave model of the matching mode.
  - rx_data equals the slave word in each mode.
  - SCLK idles at cpol before and after each frame.
- **Multi-slave:** NUM_SLAVES=4.
  - slave_sel=2 drives only SSbar=4'b1011.
  - slave_sel change mid-frame has no effect.
- **Back-to-back:** tx_valid held high for 3 frames.
  - Accepts occur at cycles 0, 69, 138.
  - SSbar is high for 1 cycle between frames.
  - rx_valid fires 3 times.
- **Reset mid-frame:** assert rst_n low at SCLK edge 7.
  - SSbar is all 1s, SCLK=0, tx_ready=1 immediately.
  - No rx_valid pulse.
  - A new frame afterwards completes correctly.
- **Loopback (macro defined):** loopback=1, tx_data=0x5A, MISO held 0 → rx_data=0x5A.

Source files
------------

// File: rtl/spi_master_param_if.sv
// Transmit/receive handshake and SPI pin bundle for spi_master_param.
// The loopback pin exists only when SPI_MASTER_LOOPBACK_EN is defined.
interface spi_master_param_if #(
    parameter int unsigned WORD_LENGTH = 8,
    parameter int unsigned NUM_SLAVES  = 1
);
    localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    logic                   tx_valid;
    logic                   tx_ready;
    logic [WORD_LENGTH-1:0] tx_data;
    logic [SEL_W-1:0]       slave_sel;
    logic                   cpol;
    logic                   cpha;
    logic                   rx_valid;
    logic [WORD_LENGTH-1:0] rx_data;
    logic                   busy;
    logic                   SCLK;
    logic                   MOSI;
    logic                   MISO;
    logic [NUM_SLAVES-1:0]  SSbar;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic                   loopback;

    modport master (
        input  tx_valid, tx_data, slave_sel, cpol, cpha, MISO, loopback,
        output tx_ready, rx_valid, rx_data, busy, SCLK, MOSI, SSbar
    );

    modport slave (
        output tx_valid, tx_data, slave_sel, cpol, cpha, MISO, loopback,
        input  tx_ready, rx_valid, rx_data, busy, SCLK, MOSI, SSbar
    );
`else
    modport master (
        input  tx_valid, tx_data, slave_sel, cpol, cpha, MISO,
        output tx_ready, rx_valid, rx_data, busy, SCLK, MOSI, SSbar
    );

    modport slave (
        output tx_valid, tx_data, slave_sel, cpol, cpha, MISO,
        input  tx_ready, rx_valid, rx_data, busy, SCLK, MOSI, SSbar
    );
`endif
endinterface

// File: rtl/spi_master_param.sv
// Parameterised SPI master with per-frame CPOL/CPHA, one-hot slave selects and valid/ready TX.
// Define SPI_MASTER_LOOPBACK_EN to add a loopback input that samples MOSI instead of MISO.
module spi_master_param #(
    parameter int unsigned WORD_LENGTH      = 8,
    parameter int unsigned CLK_PER_HALF_BIT = 4,
    parameter int unsigned NUM_SLAVES       = 1
) (
    input logic                clk,
    input logic                rst_n,
    spi_master_param_if.master bus
);
    localparam int unsigned W      = WORD_LENGTH;
    localparam int unsigned H      = CLK_PER_HALF_BIT;
    localparam int unsigned CNT_W  = $clog2(H);
    localparam int unsigned EDGE_W = $clog2(2 * W + 1);
    localparam int unsigned SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(H - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * W - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LEAD     = 2'd1,
        TRANSFER = 2'd2,
        TRAIL    = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [EDGE_W-1:0]     edge_q, edge_d;
    logic [W-1:0]          tx_sh_q, tx_sh_d;
    logic [W-1:0]          rx_sh_q, rx_sh_d;
    logic [W-1:0]          rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic [NUM_SLAVES-1:0] ss_n_q, ss_n_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  busy_q, busy_d;

    logic half_done_c;
    logic lead_edge_c;
    logic last_edge_c;
    logic sample_c;

    assign half_done_c = (cnt_q == CNT_LAST);
    // edge_q counts edges already made, so an even count means the next edge is a leading one
    assign lead_edge_c = ~edge_q[0];
    assign last_edge_c = (edge_q == EDGE_LAST);

`ifdef SPI_MASTER_LOOPBACK_EN
    assign sample_c = bus.loopback ? mosi_q : bus.MISO;
`else
    assign sample_c = bus.MISO;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            edge_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= '1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        edge_d     = edge_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;

        case (state_q)
            IDLE: begin
                sclk_d = bus.cpol;
                mosi_d = 1'b0;
                if (bus.tx_valid) begin
                    state_d = LEAD;
                    cpol_d  = bus.cpol;
                    cpha_d  = bus.cpha;
                    edge_d  = '0;
                    rx_sh_d = '0;
                    // An out-of-range select matches no line, so the frame runs deselected
                    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                        ss_n_d[i] = (bus.slave_sel != SEL_W'(i));
                    end
                    if (bus.cpha) begin
                        tx_sh_d = bus.tx_data;
                    end else begin
                        mosi_d  = bus.tx_data[W-1];
                        tx_sh_d = {bus.tx_data[W-2:0], 1'b0};
                    end
                end
            end

            LEAD, TRANSFER: begin
                cnt_d = half_done_c ? '0 : cnt_q + CNT_W'(1);
                if (half_done_c) begin
                    sclk_d  = ~sclk_q;
                    edge_d  = edge_q + EDGE_W'(1);
                    state_d = last_edge_c ? TRAIL : TRANSFER;
                    if (lead_edge_c ^ cpha_q) begin
                        rx_sh_d = {rx_sh_q[W-2:0], sample_c};
                    end else if (!last_edge_c) begin
                        mosi_d  = tx_sh_q[W-1];
                        tx_sh_d = {tx_sh_q[W-2:0], 1'b0};
                    end
                end
            end

            TRAIL: begin
                cnt_d = half_done_c ? '0 : cnt_q + CNT_W'(1);
                if (half_done_c) begin
                    state_d    = IDLE;
                    ss_n_d     = '1;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh_q;
                    sclk_d     = cpol_q;
                    mosi_d     = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                ss_n_d  = '1;
            end
        endcase

        tx_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    assign bus.tx_ready = tx_ready_q;
    assign bus.busy     = busy_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.SCLK     = sclk_q;
    assign bus.MOSI     = mosi_q;
    assign bus.SSbar    = ss_n_q;
endmodule
